// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART receiver: parity modes and FSM state encodings.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_PUSH      = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-frame buffer. Push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_3125,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is forced to zero when empty so the output reads 0 out of reset.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally at DEPTH (power of two); occupancy tells full from empty.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while the entry is not occupied.
  always_ff @(posedge clk_3125) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with mid-bit sampling, parity/stop checking and a frame FIFO.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | half a bit in, confirm the start bit is still low
// DATA      | sample DATA_BITS bits, LSB first
// PARITY    | sample parity bit and compare against running XOR
// STOP      | sample STOP_BITS stop bits, any low marks a frame error
// PUSH      | hand frame to the FIFO or flag overrun
// WAIT_HIGH | after a frame error, hold off until the line returns high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 27,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk_3125,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int FW    = DATA_BITS + 2;

  logic                 rx_meta_q, rx_sync_q;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 cnt_tc;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]        fifo_dout;

  assign cnt_tc = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign state  = state_q;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Frame datapath registers: counters, shift register and error flags.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      data_q <= '0;
      par_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      data_q <= data_d;
      par_q  <= par_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end

  // Next-state and datapath update; all sampling happens at the bit-period terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT / 2)) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            bit_d   = '0;
            data_d  = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_tc) begin
          cnt_d  = '0;
          data_d = {rx_sync_q, data_q[DATA_BITS-1:1]};
          par_d  = par_q ^ rx_sync_q;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (cnt_tc) begin
          cnt_d   = '0;
          perr_d  = (PARITY_MODE == PAR_ODD) ? ~(par_q ^ rx_sync_q) : (par_q ^ rx_sync_q);
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_tc) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rx_sync_q;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_PUSH;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PUSH:      state_d = ferr_q ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH: if (rx_sync_q) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // PUSH writes when there is room (or the head leaves this cycle), otherwise flags overrun.
  always_comb begin
    fifo_push = 1'b0;
    overrun   = 1'b0;
    if (state_q == ST_PUSH) begin
      if (!fifo_full || fifo_pop) fifo_push = 1'b1;
      else                        overrun   = 1'b1;
    end
  end

  assign rx_valid   = !fifo_empty;
  assign fifo_pop   = rx_valid && rx_ready;
  assign rx_data    = fifo_dout[FW-1:2];
  assign parity_err = fifo_dout[1];
  assign frame_err  = fifo_dout[0];

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .push_i   (fifo_push),
    .pop_i    (fifo_pop),
    .din_i    ({data_q, perr_q, ferr_q}),
    .dout_o   (fifo_dout),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an even-parity and an odd-parity instance share one serial line.
// A queue of expected frames is built from the bits put on the line and checked at the FIFO head.
module tb_uart_rx_cfg;

  localparam int CPB   = 27;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       po;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data, rx_data_o;
  logic       rx_valid, perr, ferr, ovr;
  logic       rx_valid_o, perr_o, ferr_o, ovr_o;
  logic [2:0] state, state_o;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ovr_cnt = 0;
  int   ovr_cnt_o = 0;
  int   exp_ovr = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
                .FIFO_DEPTH(DEPTH)) dut (
    .clk_3125(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(perr), .frame_err(ferr), .overrun(ovr), .state(state));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
                .FIFO_DEPTH(DEPTH)) dut_odd (
    .clk_3125(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data_o), .rx_valid(rx_valid_o),
    .rx_ready(rx_ready), .parity_err(perr_o), .frame_err(ferr_o), .overrun(ovr_o),
    .state(state_o));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    e.d  = d;
    e.pe = (^d) ^ p;
    e.po = ~((^d) ^ p);
    e.fe = ~s;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input logic p, input logic s);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = p;
    tick(CPB);
    rx = s;
    tick(CPB);
    rx = 1'b1;
  endtask

  // keep=1 means a pop is arranged for the push cycle, so a full FIFO still accepts the frame.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit keep);
    if (exp_q.size() < DEPTH || keep) exp_q.push_back(mk(d, p, s));
    else exp_ovr++;
    send_bits(d, p, s);
    tick(4);
    chk("frame_end_valid", rx_valid, exp_q.size() != 0);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
  endtask

  // Head comparison on every cycle the FIFO shows data; model pops when the DUT will pop.
  always @(negedge clk) begin : compare
    exp_t e;
    if (ovr)   ovr_cnt++;
    if (ovr_o) ovr_cnt_o++;
    if (rst_n && rx_valid) begin
      if (exp_q.size() == 0) begin
        chk("valid_without_expected", rx_valid, 0);
      end else begin
        e = exp_q[0];
        chk("head_data", rx_data, e.d);
        chk("head_perr", perr, e.pe);
        chk("head_ferr", ferr, e.fe);
        chk("odd_valid", rx_valid_o, 1);
        chk("odd_data", rx_data_o, e.d);
        chk("odd_perr", perr_o, e.po);
        chk("odd_ferr", ferr_o, e.fe);
        if (rx_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic       p, s;
    bit         seen;
    bit         done;
    rst_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_perr", perr, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_state", state, 0);
    chk("rst_state_odd", state_o, 0);
    rst_n = 1'b1;
    tick(5);

    // 0x41 with correct even parity
    send_frame(8'h41, 1'b0, 1'b1, 0);
    chk("t41_valid", rx_valid, 1);
    chk("t41_data", rx_data, 8'h41);
    chk("t41_perr", perr, 0);
    chk("t41_ferr", ferr, 0);
    chk("t41_odd_perr", perr_o, 1);
    pop_one();
    chk("t41_popped", rx_valid, 0);

    // 0x41 with parity bit 1
    send_frame(8'h41, 1'b1, 1'b1, 0);
    chk("t41p1_data", rx_data, 8'h41);
    chk("t41p1_perr", perr, 1);
    chk("t41p1_odd_perr", perr_o, 0);
    pop_one();

    // false start: 10 low cycles
    rx = 1'b0;
    tick(5);
    chk("fs_in_start", state, 1);
    tick(5);
    rx = 1'b1;
    tick(40);
    chk("fs_idle", state, 0);
    chk("fs_no_push", rx_valid, 0);

    // break: 15 bit times low
    exp_q.push_back(mk(8'h00, 1'b0, 1'b0));
    rx = 1'b0;
    tick(15 * CPB);
    chk("brk_state", state, 6);
    chk("brk_state_odd", state_o, 6);
    chk("brk_valid", rx_valid, 1);
    chk("brk_data", rx_data, 8'h00);
    chk("brk_ferr", ferr, 1);
    rx = 1'b1;
    tick(5);
    chk("brk_recover", state, 0);
    pop_one();

    // overfill with consumer stalled
    for (int k = 0; k < 5; k++) begin
      b = 8'(8'h10 + k);
      send_frame(b, ^b, 1'b1, 0);
    end
    chk("fill_ovr_lit", ovr_cnt, 1);
    chk("fill_ovr_model", ovr_cnt, exp_ovr);
    chk("fill_head", rx_data, 8'h10);

    // push into a full FIFO while the head is popped in the same cycle
    seen = 1'b0;
    b = 8'h20;
    fork
      send_frame(b, ^b, 1'b1, 1);
      begin
        for (int i = 0; i < CPB * 14; i++) begin
          tick(1);
          if (state == 3'd5) begin
            seen = 1'b1;
            break;
          end
        end
        chk("push_seen", seen, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    chk("full_pop_no_ovr", ovr_cnt, 1);
    chk("full_pop_head", rx_data, 8'h11);
    rx_ready = 1'b1;
    tick(10);
    rx_ready = 1'b0;
    chk("drain_empty", rx_valid, 0);
    chk("drain_model_empty", exp_q.size(), 0);

    // reset during a frame discards both the frame and the FIFO
    b = 8'h33;
    send_frame(b, ^b, 1'b1, 0);
    chk("pre_rst_valid", rx_valid, 1);
    b = 8'h5A;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rst_n = 1'b0;
    exp_q.delete();
    rx = 1'b1;
    tick(2);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_data", rx_data, 0);
    rst_n = 1'b1;
    tick(2 * CPB);
    chk("post_rst_idle", state, 0);
    chk("post_rst_empty", rx_valid, 0);
    b = 8'h55;
    send_frame(b, ^b, 1'b1, 0);
    chk("post_rst_data", rx_data, 8'h55);
    chk("post_rst_perr", perr, 0);
    pop_one();

    // randomized frames with a randomly ready consumer
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          b = 8'($urandom);
          p = ($urandom_range(0, 3) == 0) ? ~^b : ^b;
          s = ($urandom_range(0, 7) != 0);
          send_frame(b, p, s, 0);
          tick(int'($urandom_range(0, 20)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
        rx_ready = 1'b0;
      end
    join
    rx_ready = 1'b1;
    tick(8);
    rx_ready = 1'b0;
    chk("final_empty", rx_valid, 0);
    chk("final_model_empty", exp_q.size(), 0);
    chk("final_ovr", ovr_cnt, exp_ovr);
    chk("final_ovr_odd", ovr_cnt_o, exp_ovr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
